// File: rtl/reg_seq_pkg.sv
// Shared definitions for the register-file sequencer: op codes, FSM states and default widths.
package reg_seq_pkg;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_SEL_WIDTH   = 8;
    localparam int DEF_COUNT_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_LDI  = 3'd0,
        OP_MOV  = 3'd1,
        OP_RD   = 3'd2,
        OP_POST = 3'd3,
        OP_PRE  = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/reg_file_sequencer.sv
// One-at-a-time register-file initiator: accept -> EXEC (-> WRITE for MOV) (-> RESP for reads).
// Read data appears 2 edges after accept; cmd_ready is low until the op and its response complete.
module reg_file_sequencer
    import reg_seq_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SEL_WIDTH   = DEF_SEL_WIDTH,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [SEL_WIDTH-1:0]   cmd_src,
    input  logic [SEL_WIDTH-1:0]   cmd_dst,
    input  logic [WIDTH-1:0]       cmd_imm,
    input  logic [COUNT_WIDTH-1:0] cmd_count,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    output logic [WIDTH-1:0]       in,
    output logic                   ld,
    output logic [SEL_WIDTH-1:0]   sel_in,
    output logic [SEL_WIDTH-1:0]   sel_a,
    output logic [SEL_WIDTH-1:0]   sel_b,
    output logic                   oe_a,
    output logic                   oe_b,
    output logic [COUNT_WIDTH-1:0] count_a,
    output logic                   pre_count_a,
    output logic                   post_count_a
);

    state_e                 r_state;
    logic [2:0]             r_op;
    logic [SEL_WIDTH-1:0]   r_src;
    logic [SEL_WIDTH-1:0]   r_dst;
    logic [WIDTH-1:0]       r_imm;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [WIDTH-1:0]       r_cap;
    logic [WIDTH-1:0]       r_rsp_data;
    logic                   w_accept;

    assign w_accept = cmd_valid && (r_state == IDLE);
    assign rsp_data = r_rsp_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_op       <= '0;
            r_src      <= '0;
            r_dst      <= '0;
            r_imm      <= '0;
            r_count    <= '0;
            r_cap      <= '0;
            r_rsp_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op    <= cmd_op;
                        r_src   <= cmd_src;
                        r_dst   <= cmd_dst;
                        r_imm   <= cmd_imm;
                        r_count <= cmd_count;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    case (r_op)
                        OP_MOV: begin
                            r_cap   <= b;
                            r_state <= WRITE;
                        end
                        // PRE sees reg+count on a, POST sees the old value; both captured here.
                        OP_RD, OP_POST, OP_PRE: begin
                            r_rsp_data <= a;
                            r_state    <= RESP;
                        end
                        default: r_state <= IDLE;
                    endcase
                end
                WRITE: r_state <= IDLE;
                RESP: begin
                    if (rsp_ready) r_state <= IDLE;
                end
            endcase
        end
    end

    // Controls depend only on registered state/fields, so they are stable for the whole cycle.
    always_comb begin
        cmd_ready    = (r_state == IDLE);
        rsp_valid    = (r_state == RESP);
        in           = '0;
        ld           = 1'b0;
        sel_in       = '0;
        sel_a        = '0;
        sel_b        = '0;
        oe_a         = 1'b0;
        oe_b         = 1'b0;
        count_a      = '0;
        pre_count_a  = 1'b0;
        post_count_a = 1'b0;
        case (r_state)
            EXEC: begin
                case (r_op)
                    OP_LDI: begin
                        sel_in = r_dst;
                        in     = r_imm;
                        ld     = 1'b1;
                    end
                    OP_MOV: begin
                        sel_b = r_src;
                        oe_b  = 1'b1;
                    end
                    OP_RD: begin
                        sel_a = r_src;
                        oe_a  = 1'b1;
                    end
                    OP_POST: begin
                        sel_a        = r_src;
                        oe_a         = 1'b1;
                        count_a      = r_count;
                        post_count_a = 1'b1;
                    end
                    OP_PRE: begin
                        sel_a       = r_src;
                        oe_a        = 1'b1;
                        count_a     = r_count;
                        pre_count_a = 1'b1;
                    end
                    default: ;
                endcase
            end
            WRITE: begin
                sel_in = r_dst;
                in     = r_cap;
                ld     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_file_sequencer.sv
// Bench for reg_file_sequencer: behavioural register file, directed table, corner sequences, random ops vs a shadow model.
module tb_reg_file_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_src;
    logic [7:0]  cmd_dst;
    logic [31:0] cmd_imm;
    logic [7:0]  cmd_count;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [31:0] rf_a;
    logic [31:0] rf_b;
    logic [31:0] rf_in;
    logic        ld;
    logic [7:0]  sel_in;
    logic [7:0]  sel_a;
    logic [7:0]  sel_b;
    logic        oe_a;
    logic        oe_b;
    logic [7:0]  count_a;
    logic        pre_count_a;
    logic        post_count_a;

    int checks = 0;
    int errors = 0;

    logic [31:0] regs  [256];
    logic [31:0] model [256];

    reg_file_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm), .cmd_count(cmd_count),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .a(rf_a), .b(rf_b), .in(rf_in), .ld(ld),
        .sel_in(sel_in), .sel_a(sel_a), .sel_b(sel_b),
        .oe_a(oe_a), .oe_b(oe_b), .count_a(count_a),
        .pre_count_a(pre_count_a), .post_count_a(post_count_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] sext(input logic [7:0] c);
        return {{24{c[7]}}, c};
    endfunction

    // Behavioural register file: PRE presents reg+count on a, both count kinds update at the edge.
    assign rf_a = !oe_a ? 32'd0 : (pre_count_a ? regs[sel_a] + sext(count_a) : regs[sel_a]);
    assign rf_b = oe_b ? regs[sel_b] : 32'd0;

    always @(posedge clk) begin
        if (ld) regs[sel_in] <= rf_in;
        if (pre_count_a || post_count_a) regs[sel_a] <= regs[sel_a] + sext(count_a);
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string name);
        check1({name, "_ld"}, ld, 1'b0);
        check1({name, "_oe_a"}, oe_a, 1'b0);
        check1({name, "_oe_b"}, oe_b, 1'b0);
        check1({name, "_pre"}, pre_count_a, 1'b0);
        check1({name, "_post"}, post_count_a, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check1("inv_one_oe", oe_a && oe_b, 1'b0);
            check1("inv_one_count", pre_count_a && post_count_a, 1'b0);
            check1("inv_count_needs_oe_a", (pre_count_a || post_count_a) && !oe_a, 1'b0);
            check1("inv_oe_b_ld_same_reg", oe_b && ld && (sel_b == sel_in), 1'b0);
        end
    end

    // Issues one command from IDLE, checks its bus pattern and timing, and its response against the model.
    task automatic run_cmd(input logic [2:0] op, input logic [7:0] src, input logic [7:0] dst,
                           input logic [31:0] imm, input logic [7:0] cnt, input int stall,
                           output logic [31:0] got);
        logic [31:0] exp;
        bit has_rsp;
        got = '0;
        exp = '0;
        has_rsp = (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
        case (op)
            3'd0: model[dst] = imm;
            3'd1: model[dst] = model[src];
            3'd2: exp = model[src];
            3'd3: begin exp = model[src]; model[src] = model[src] + sext(cnt); end
            3'd4: begin model[src] = model[src] + sext(cnt); exp = model[src]; end
            default: ;
        endcase
        check1("idle_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_imm = imm; cmd_count = cnt;
        @(negedge clk);
        cmd_valid = 1'b0;
        check1("busy_after_accept", cmd_ready, 1'b0);
        case (op)
            3'd0: begin
                check1("ldi_ld", ld, 1'b1);
                check32("ldi_sel_in", 32'(sel_in), 32'(dst));
                check32("ldi_in", rf_in, imm);
            end
            3'd1: begin
                check1("mov_oe_b", oe_b, 1'b1);
                check32("mov_sel_b", 32'(sel_b), 32'(src));
                check1("mov_exec_ld", ld, 1'b0);
            end
            3'd2, 3'd3, 3'd4: begin
                check1("rd_oe_a", oe_a, 1'b1);
                check32("rd_sel_a", 32'(sel_a), 32'(src));
                check1("post_strobe", post_count_a, op == 3'd3);
                check1("pre_strobe", pre_count_a, op == 3'd4);
                if (op != 3'd2) check32("count_a", 32'(count_a), 32'(cnt));
            end
            default: check_quiet("illegal_exec");
        endcase
        @(negedge clk);
        if (op == 3'd1) begin
            check1("mov_write_ld", ld, 1'b1);
            check1("mov_write_oe_b", oe_b, 1'b0);
            check32("mov_sel_in", 32'(sel_in), 32'(dst));
            check32("mov_in", rf_in, model[dst]);
            @(negedge clk);
        end
        if (has_rsp) begin
            check1("rsp_latency", rsp_valid, 1'b1);
            check32("rsp_data", rsp_data, exp);
            got = rsp_data;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check1("stall_valid", rsp_valid, 1'b1);
                check32("stall_data", rsp_data, got);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
        check1("ready_back", cmd_ready, 1'b1);
        check1("rsp_cleared", rsp_valid, 1'b0);
        check1("no_ld_in_idle", ld, 1'b0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  src;
        logic [7:0]  dst;
        logic [31:0] imm;
        logic [7:0]  cnt;
        bit          has_rsp;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[18];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        for (int i = 0; i < 256; i++) begin
            regs[i]  = '0;
            model[i] = '0;
        end
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_src = '0; cmd_dst = '0;
        cmd_imm = '0; cmd_count = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check1("rst_cmd_ready", cmd_ready, 1'b1);
        check1("rst_rsp_valid", rsp_valid, 1'b0);
        check32("rst_rsp_data", rsp_data, 32'd0);
        check32("rst_buses", {rf_in[23:0], sel_in}, 32'd0);
        check32("rst_sel_count", {sel_a, sel_b, count_a, 8'd0}, 32'd0);
        check_quiet("rst");

        vecs[0]  = '{3'd0, 8'd0, 8'd2, 32'd123,       8'd0,   1'b0, 32'd0};
        vecs[1]  = '{3'd2, 8'd2, 8'd0, 32'd0,         8'd0,   1'b1, 32'd123};
        vecs[2]  = '{3'd0, 8'd0, 8'd3, 32'd321,       8'd0,   1'b0, 32'd0};
        vecs[3]  = '{3'd1, 8'd3, 8'd5, 32'd0,         8'd0,   1'b0, 32'd0};
        vecs[4]  = '{3'd2, 8'd5, 8'd0, 32'd0,         8'd0,   1'b1, 32'd321};
        vecs[5]  = '{3'd2, 8'd3, 8'd0, 32'd0,         8'd0,   1'b1, 32'd321};
        vecs[6]  = '{3'd0, 8'd0, 8'd2, 32'd567,       8'd0,   1'b0, 32'd0};
        vecs[7]  = '{3'd3, 8'd2, 8'd0, 32'd0,         8'd5,   1'b1, 32'd567};
        vecs[8]  = '{3'd2, 8'd2, 8'd0, 32'd0,         8'd0,   1'b1, 32'd572};
        vecs[9]  = '{3'd3, 8'd2, 8'd0, 32'd0,         8'hFA,  1'b1, 32'd572};
        vecs[10] = '{3'd2, 8'd2, 8'd0, 32'd0,         8'd0,   1'b1, 32'd566};
        vecs[11] = '{3'd4, 8'd3, 8'd0, 32'd0,         8'd2,   1'b1, 32'd323};
        vecs[12] = '{3'd2, 8'd3, 8'd0, 32'd0,         8'd0,   1'b1, 32'd323};
        vecs[13] = '{3'd0, 8'd0, 8'd7, 32'hFFFF_FFFF, 8'd0,   1'b0, 32'd0};
        vecs[14] = '{3'd3, 8'd7, 8'd0, 32'd0,         8'd1,   1'b1, 32'hFFFF_FFFF};
        vecs[15] = '{3'd2, 8'd7, 8'd0, 32'd0,         8'd0,   1'b1, 32'd0};
        vecs[16] = '{3'd6, 8'd2, 8'd2, 32'hDEAD_BEEF, 8'd3,   1'b0, 32'd0};
        vecs[17] = '{3'd2, 8'd2, 8'd0, 32'd0,         8'd0,   1'b1, 32'd566};

        foreach (vecs[i]) begin
            run_cmd(vecs[i].op, vecs[i].src, vecs[i].dst, vecs[i].imm, vecs[i].cnt, 0, got);
            if (vecs[i].has_rsp) check32($sformatf("tbl%0d_rsp", i), got, vecs[i].exp);
        end

        // Held response: stable data, no accept of a waiting command.
        run_cmd(3'd0, 8'd0, 8'd9, 32'hABCD_0123, 8'd0, 0, got);
        cmd_valid = 1'b1; cmd_op = 3'd2; cmd_src = 8'd9;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check1("hold_valid0", rsp_valid, 1'b1);
        check32("hold_data0", rsp_data, 32'hABCD_0123);
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_dst = 8'd9; cmd_imm = 32'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check1("hold_valid", rsp_valid, 1'b1);
            check32("hold_data", rsp_data, 32'hABCD_0123);
            check1("hold_cmd_ready", cmd_ready, 1'b0);
            check1("hold_no_ld", ld, 1'b0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check1("hold_release_ready", cmd_ready, 1'b1);
        check1("hold_release_valid", rsp_valid, 1'b0);
        run_cmd(3'd2, 8'd9, 8'd0, 32'd0, 8'd0, 0, got);
        check32("ignored_cmd_no_write", got, 32'hABCD_0123);

        // Reset while a read response is pending.
        cmd_valid = 1'b1; cmd_op = 3'd2; cmd_src = 8'd9;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check1("rstresp_valid_before", rsp_valid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check1("rstresp_valid", rsp_valid, 1'b0);
        check1("rstresp_ready", cmd_ready, 1'b1);
        check32("rstresp_data", rsp_data, 32'd0);
        check_quiet("rstresp");
        rst = 1'b0;
        @(negedge clk);
        check1("rstresp_still_idle", rsp_valid, 1'b0);

        // Reset during the EXEC of a MOV: destination must not be written.
        run_cmd(3'd0, 8'd0, 8'd10, 32'h55, 8'd0, 0, got);
        run_cmd(3'd0, 8'd0, 8'd11, 32'h77, 8'd0, 0, got);
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_src = 8'd10; cmd_dst = 8'd11;
        @(negedge clk);
        cmd_valid = 1'b0;
        check1("rstmov_oe_b", oe_b, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_quiet("rstmov");
        check1("rstmov_ready", cmd_ready, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check_quiet("rstmov_after");
        run_cmd(3'd2, 8'd11, 8'd0, 32'd0, 8'd0, 0, got);
        check32("rstmov_dst_kept", got, 32'h77);

        for (int n = 0; n < 150; n++) begin
            run_cmd(3'($urandom_range(0, 7)), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                    32'($urandom), 8'($urandom), $urandom_range(0, 3), got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
